agendador_medidas: RTL and testbench

Round-robin scheduler sharing one ultrasonic measurement unit and one serial transmitter among `NUM_SENSORES` sensors. Per sweep: trigger each sensor, wait for its result with a timeout, transmit the 3 BCD digits as ASCII plus a separator, and close the sweep with `#`. Sits between the game top level and the shared `medir`/serial datapath. Replaces ad-hoc per-sensor sequencing with one configurable controller.

---
 rtl/agendador_pkg.sv | 35 +++
 rtl/agendador_medidas_if.sv | 32 +++
 rtl/agendador_medidas_contador_ciclos.sv | 33 +++
 rtl/agendador_medidas.sv | 186 ++++++++++++++++++
 tb/tb_agendador_medidas.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/agendador_pkg.sv
// Shared definitions for the measurement scheduler.
//   estado_t          : FSM state codes (values are also the debug display code)
//   ASCII_*           : bytes sent on the serial link
//   BYTES_POR_SENSOR  : bytes in one sensor frame (3 digits + separator)
//   digito_ascii()    : one BCD digit to ASCII, '?' when invalid
package agendador_pkg;

    typedef enum logic [3:0] {
        OCIOSO        = 4'd0,
        DISPARA       = 4'd1,
        ESPERA_MEDIDA = 4'd2,
        CAPTURA       = 4'd3,
        TX_INICIA     = 4'd4,
        TX_ESPERA     = 4'd5,
        PROX_BYTE     = 4'd6,
        PROX_SENSOR   = 4'd7,
        FIM           = 4'd8,
        INTERVALO     = 4'd9
    } estado_t;

    localparam logic [7:0] ASCII_ZERO         = 8'h30;
    localparam logic [7:0] ASCII_VIRGULA      = 8'h2C;
    localparam logic [7:0] ASCII_CERQUILHA    = 8'h23;
    localparam logic [7:0] ASCII_INTERROGACAO = 8'h3F;

    localparam int BYTES_POR_SENSOR = 4;

    function automatic logic [7:0] digito_ascii(input logic [3:0] digito, input logic invalido);
        if (invalido || digito > 4'd9) begin
            return ASCII_INTERROGACAO;
        end
        return ASCII_ZERO + {4'h0, digito};
    endfunction

endpackage

// File: rtl/agendador_medidas_if.sv
// Bus between the scheduler and the shared measurement/serial datapath.
//   medir         : one-cycle trigger to the measurement unit
//   sel_sensor    : sensor currently served
//   pronto_medida : one-cycle pulse, medida valid
//   medida        : BCD hundreds[11:8], tens[7:4], units[3:0]
//   partida_tx    : one-cycle start to the serial transmitter
//   dado_tx       : ASCII byte, stable from partida_tx until pronto_tx
//   pronto_tx     : one-cycle pulse, byte sent
// master = scheduler side, slave = datapath side.
interface agendador_medidas_if #(
    parameter int W_SEL = 1
);

    logic             medir;
    logic [W_SEL-1:0] sel_sensor;
    logic             pronto_medida;
    logic [11:0]      medida;
    logic             partida_tx;
    logic [7:0]       dado_tx;
    logic             pronto_tx;

    modport master (
        output medir, sel_sensor, partida_tx, dado_tx,
        input  pronto_medida, medida, pronto_tx
    );

    modport slave (
        input  medir, sel_sensor, partida_tx, dado_tx,
        output pronto_medida, medida, pronto_tx
    );

endinterface

// File: rtl/agendador_medidas_contador_ciclos.sv
// Cycle counter used for the measurement timeout and the sweep interval.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   zera          : clear to 0 (wins over conta)
//   conta         : advance by one, holding at LIMITE-1
//   fim_contagem  : high while the count equals LIMITE-1
module contador_ciclos #(
    parameter int LIMITE  = 2,
    parameter int LARGURA = (LIMITE > 1) ? $clog2(LIMITE) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim_contagem
);

    localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(LIMITE - 1);

    logic [LARGURA-1:0] contagem;

    // NOTE: sequential state is written with <= so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            contagem <= '0;
        end else if (conta && contagem != ULTIMO) begin
            contagem <= contagem + 1'b1;
        end
    end

    assign fim_contagem = (contagem == ULTIMO);

endmodule

// File: rtl/agendador_medidas.sv
// Round-robin scheduler: per sweep triggers each sensor, waits for its result
// (with timeout), sends "DDD," per sensor over serial and closes with '#'.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   iniciar       : start one sweep (sampled only when idle)
//   continuo      : repeat sweeps every INTERVALO_CICLOS cycles
//   bus           : measurement / serial handshake (master side)
//   ocupado       : high in every state except OCIOSO
//   fim           : one-cycle pulse at sweep end
//   erro_timeout  : sticky, some sensor timed out this sweep
//   db_estado     : state code, 4'hF for an unused encoding
module agendador_medidas
    import agendador_pkg::*;
#(
    parameter int NUM_SENSORES     = 2,
    parameter int TIMEOUT_CICLOS   = 1_500_000,
    parameter int INTERVALO_CICLOS = 25_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                continuo,
    agendador_medidas_if.master bus,
    output logic                ocupado,
    output logic                fim,
    output logic                erro_timeout,
    output logic [3:0]          db_estado
);

    localparam int W_SEL = (NUM_SENSORES > 1) ? $clog2(NUM_SENSORES) : 1;
    localparam logic [W_SEL-1:0] ULTIMO_SENSOR = W_SEL'(NUM_SENSORES - 1);
    localparam logic [1:0]       ULTIMO_BYTE   = 2'(BYTES_POR_SENSOR - 1);

    estado_t          estado, estado_d;
    logic [W_SEL-1:0] sel_q, sel_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [11:0]      medida_q, medida_d;
    logic             invalido_q, invalido_d;
    logic             erro_q, erro_d;
    logic [7:0]       dado_q, dado_d;
    logic [7:0]       byte_tx;

    logic fim_timeout, fim_intervalo;
    logic zera_timeout, conta_timeout, zera_intervalo, conta_intervalo;

    assign zera_timeout    = (estado == DISPARA);
    assign conta_timeout   = (estado == ESPERA_MEDIDA);
    assign zera_intervalo  = (estado == FIM);
    assign conta_intervalo = (estado == INTERVALO);

    contador_ciclos #(.LIMITE(TIMEOUT_CICLOS)) u_timeout (
        .clock        (clock),
        .reset        (reset),
        .zera         (zera_timeout),
        .conta        (conta_timeout),
        .fim_contagem (fim_timeout)
    );

    // Terminal count one earlier than the interval so that, with FIM and the
    // DISPARA cycle included, fim-to-medir spans exactly INTERVALO_CICLOS.
    contador_ciclos #(.LIMITE(INTERVALO_CICLOS - 1)) u_intervalo (
        .clock        (clock),
        .reset        (reset),
        .zera         (zera_intervalo),
        .conta        (conta_intervalo),
        .fim_contagem (fim_intervalo)
    );

    // NOTE: every register is reset (not just the state) because all outputs,
    // including the registered dado_tx, must read 0 right after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= OCIOSO;
            sel_q      <= '0;
            byte_idx_q <= '0;
            medida_q   <= '0;
            invalido_q <= 1'b0;
            erro_q     <= 1'b0;
            dado_q     <= '0;
        end else begin
            estado     <= estado_d;
            sel_q      <= sel_d;
            byte_idx_q <= byte_idx_d;
            medida_q   <= medida_d;
            invalido_q <= invalido_d;
            erro_q     <= erro_d;
            dado_q     <= dado_d;
        end
    end

    // NOTE: every variable gets its hold value first so no path through the
    // case leaves one unassigned, which would infer a latch.
    always_comb begin
        estado_d   = estado;
        sel_d      = sel_q;
        byte_idx_d = byte_idx_q;
        medida_d   = medida_q;
        invalido_d = invalido_q;
        erro_d     = erro_q;

        case (estado)
            OCIOSO: begin
                if (iniciar || continuo) begin
                    estado_d   = DISPARA;
                    sel_d      = '0;
                    byte_idx_d = '0;
                    erro_d     = 1'b0;
                end
            end
            DISPARA: estado_d = ESPERA_MEDIDA;
            ESPERA_MEDIDA: begin
                // A result arriving on the expiry cycle takes priority.
                if (bus.pronto_medida) begin
                    medida_d   = bus.medida;
                    invalido_d = 1'b0;
                    estado_d   = CAPTURA;
                end else if (fim_timeout) begin
                    invalido_d = 1'b1;
                    erro_d     = 1'b1;
                    estado_d   = CAPTURA;
                end
            end
            CAPTURA: begin
                byte_idx_d = '0;
                estado_d   = TX_INICIA;
            end
            TX_INICIA: estado_d = TX_ESPERA;
            TX_ESPERA: begin
                if (bus.pronto_tx) begin
                    estado_d = PROX_BYTE;
                end
            end
            PROX_BYTE: begin
                if (byte_idx_q < ULTIMO_BYTE) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    estado_d   = TX_INICIA;
                end else begin
                    estado_d = PROX_SENSOR;
                end
            end
            PROX_SENSOR: begin
                if (sel_q < ULTIMO_SENSOR) begin
                    sel_d    = sel_q + W_SEL'(1);
                    estado_d = DISPARA;
                end else begin
                    estado_d = FIM;
                end
            end
            FIM: estado_d = continuo ? INTERVALO : OCIOSO;
            INTERVALO: begin
                if (!continuo) begin
                    estado_d = OCIOSO;
                end else if (fim_intervalo) begin
                    estado_d   = DISPARA;
                    sel_d      = '0;
                    byte_idx_d = '0;
                    erro_d     = 1'b0;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Byte selected by the index that will be current in TX_INICIA, so
    // dado_tx is already valid in the cycle partida_tx is high.
    always_comb begin
        byte_tx = ASCII_VIRGULA;
        case (byte_idx_d)
            2'd0:    byte_tx = digito_ascii(medida_q[11:8], invalido_q);
            2'd1:    byte_tx = digito_ascii(medida_q[7:4], invalido_q);
            2'd2:    byte_tx = digito_ascii(medida_q[3:0], invalido_q);
            default: byte_tx = (sel_q == ULTIMO_SENSOR) ? ASCII_CERQUILHA : ASCII_VIRGULA;
        endcase
    end

    assign dado_d = (estado_d == TX_INICIA) ? byte_tx : dado_q;

    assign bus.medir      = (estado == DISPARA);
    assign bus.partida_tx = (estado == TX_INICIA);
    assign bus.sel_sensor = sel_q;
    assign bus.dado_tx    = dado_q;
    assign ocupado        = (estado != OCIOSO);
    assign fim            = (estado == FIM);
    assign erro_timeout   = erro_q;
    assign db_estado      = (estado > INTERVALO) ? 4'hF : estado;

endmodule

// File: tb/tb_agendador_medidas.sv
// Directed bench for agendador_medidas with 2 sensors, 20-cycle timeout and
// 50-cycle sweep interval. Stimulus and sampling happen 1 time unit after
// each rising edge.
module tb_agendador_medidas;

    localparam int NUM_SENSORES     = 2;
    localparam int TIMEOUT_CICLOS   = 20;
    localparam int INTERVALO_CICLOS = 50;
    localparam int W_SEL            = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       continuo;
    logic       ocupado;
    logic       fim;
    logic       erro_timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    agendador_medidas_if #(.W_SEL(W_SEL)) bus ();

    agendador_medidas #(
        .NUM_SENSORES     (NUM_SENSORES),
        .TIMEOUT_CICLOS   (TIMEOUT_CICLOS),
        .INTERVALO_CICLOS (INTERVALO_CICLOS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .continuo     (continuo),
        .bus          (bus),
        .ocupado      (ocupado),
        .fim          (fim),
        .erro_timeout (erro_timeout),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic esperar_medir(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.medir === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic esperar_fim(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (fim === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Called in the medir cycle; pulses pronto_medida on wait cycle atraso+1.
    task automatic responder(input int atraso, input logic [11:0] valor);
        tick();
        repeat (atraso) tick();
        bus.pronto_medida = 1'b1;
        bus.medida        = valor;
        tick();
        bus.pronto_medida = 1'b0;
        bus.medida        = 12'hEEE;
    endtask

    task automatic receber_byte(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.partida_tx === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        b = bus.dado_tx;
        tick();
        tick();
        bus.pronto_tx = 1'b1;
        tick();
        bus.pronto_tx = 1'b0;
    endtask

    task automatic receber_bytes(input int n, inout logic [63:0] quadro, output bit ok);
        logic [7:0] b;
        bit         ok_b;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            receber_byte(b, ok_b);
            ok     = ok & ok_b;
            quadro = {quadro[55:0], b};
        end
    endtask

    task automatic servir_sensor(input bit responde, input logic [11:0] valor, input int atraso,
                                 inout logic [63:0] quadro, output logic sel, output bit ok);
        bit ok_b;
        esperar_medir(ok);
        sel = bus.sel_sensor;
        if (responde) responder(atraso, valor);
        receber_bytes(4, quadro, ok_b);
        ok = ok & ok_b;
    endtask

    task automatic varrer(input logic [11:0] v0, input int a0, input logic [11:0] v1, input int a1,
                          output logic [63:0] quadro, output logic [1:0] sels, output bit ok);
        bit   ok_s;
        logic sel;
        quadro = '0;
        servir_sensor(1'b1, v0, a0, quadro, sel, ok);
        sels[0] = sel;
        servir_sensor(1'b1, v1, a1, quadro, sel, ok_s);
        sels[1] = sel;
        ok = ok & ok_s;
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        iniciar           = 1'b0;
        continuo          = 1'b0;
        bus.pronto_medida = 1'b0;
        bus.medida        = '0;
        bus.pronto_tx     = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.medir, bus.partida_tx, ocupado, fim, erro_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.medir, bus.partida_tx, ocupado, fim, erro_timeout});
        end
        checks++;
        if (bus.sel_sensor !== 1'b0 || bus.dado_tx !== 8'h00 || db_estado !== 4'h0) begin
            errors++;
            $display("FAIL reset_values: got sel=%0h dado=%0h estado=%0h expected 0 0 0",
                     bus.sel_sensor, bus.dado_tx, db_estado);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (db_estado !== 4'h0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got estado=%0h ocupado=%b expected 0 0", db_estado, ocupado);
        end
    endtask

    task automatic test_single_sweep();
        logic [63:0] quadro;
        logic [1:0]  sels;
        bit          ok;
        int          nfim;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        checks++;
        if (bus.medir !== 1'b1) begin
            errors++;
            $display("FAIL single_medir_latency: got %b expected 1", bus.medir);
        end
        varrer(12'h123, 5, 12'h045, 0, quadro, sels, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_handshake: got timeout expected all handshakes");
        end
        checks++;
        if (quadro !== "123,045#") begin
            errors++;
            $display("FAIL single_bytes: got %s expected 123,045#", quadro);
        end
        checks++;
        if (sels !== 2'b10) begin
            errors++;
            $display("FAIL single_sel_sequence: got %b expected 10", sels);
        end
        nfim = 0;
        repeat (10) begin
            tick();
            if (fim === 1'b1) nfim++;
        end
        checks++;
        if (nfim != 1) begin
            errors++;
            $display("FAIL single_fim_pulses: got %0d expected 1", nfim);
        end
        checks++;
        if (ocupado !== 1'b0 || erro_timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_end_state: got ocupado=%b erro=%b expected 0 0", ocupado, erro_timeout);
        end
    endtask

    task automatic test_latency_and_reset();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        tick();
        bus.pronto_medida = 1'b1;
        bus.medida        = 12'h321;
        tick();
        bus.pronto_medida = 1'b0;
        bus.medida        = 12'hEEE;
        checks++;
        if (bus.partida_tx !== 1'b0 || db_estado !== 4'd3) begin
            errors++;
            $display("FAIL lat_captura: got partida=%b estado=%0h expected 0 3", bus.partida_tx, db_estado);
        end
        tick();
        checks++;
        if (bus.partida_tx !== 1'b1 || bus.dado_tx !== 8'h33) begin
            errors++;
            $display("FAIL lat_first_digit: got partida=%b dado=%0h expected 1 33", bus.partida_tx, bus.dado_tx);
        end
        tick();
        tick();
        bus.pronto_tx = 1'b1;
        tick();
        bus.pronto_tx = 1'b0;
        checks++;
        if (bus.partida_tx !== 1'b0 || db_estado !== 4'd6) begin
            errors++;
            $display("FAIL lat_prox_byte: got partida=%b estado=%0h expected 0 6", bus.partida_tx, db_estado);
        end
        tick();
        checks++;
        if (bus.partida_tx !== 1'b1 || bus.dado_tx !== 8'h32) begin
            errors++;
            $display("FAIL lat_second_digit: got partida=%b dado=%0h expected 1 32", bus.partida_tx, bus.dado_tx);
        end
        tick();
        checks++;
        if (db_estado !== 4'd5) begin
            errors++;
            $display("FAIL lat_tx_espera: got estado=%0h expected 5", db_estado);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.medir, bus.partida_tx, ocupado, fim, erro_timeout, bus.sel_sensor, bus.dado_tx, db_estado} !== 18'b0) begin
            errors++;
            $display("FAIL reset_mid_tx: got estado=%0h dado=%0h ocupado=%b expected all zero",
                     db_estado, bus.dado_tx, ocupado);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        logic [63:0] quadro;
        logic        sel;
        bit          ok;
        int          n;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        quadro = '0;
        servir_sensor(1'b1, 12'h123, 0, quadro, sel, ok);
        checks++;
        if (!ok || quadro !== {32'h0, "123,"}) begin
            errors++;
            $display("FAIL timeout_sensor0: got %s ok=%b expected 123,", quadro, ok);
        end
        esperar_medir(ok);
        checks++;
        if (!ok || bus.sel_sensor !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sensor1_medir: got ok=%b sel=%b expected 1 1", ok, bus.sel_sensor);
        end
        // medir cycle, 20 wait cycles, CAPTURA, then TX_INICIA 22 cycles on.
        n = 0;
        while (bus.partida_tx !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n != 22) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected 22", n);
        end
        checks++;
        if (erro_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag_set: got %b expected 1", erro_timeout);
        end
        quadro = '0;
        receber_bytes(4, quadro, ok);
        checks++;
        if (!ok || quadro !== {32'h0, "???#"}) begin
            errors++;
            $display("FAIL timeout_bytes: got %s ok=%b expected ???#", quadro, ok);
        end
        esperar_fim(ok);
        tick();
        tick();
        checks++;
        if (!ok || erro_timeout !== 1'b1 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got fim_ok=%b erro=%b ocupado=%b expected 1 1 0", ok, erro_timeout, ocupado);
        end
    endtask

    task automatic test_expiry_tie();
        logic [63:0] quadro;
        logic [1:0]  sels;
        bit          ok;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        checks++;
        if (erro_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tie_erro_cleared: got %b expected 0", erro_timeout);
        end
        varrer(12'h999, 19, 12'h045, 0, quadro, sels, ok);
        checks++;
        if (!ok || quadro !== "999,045#") begin
            errors++;
            $display("FAIL tie_bytes: got %s ok=%b expected 999,045#", quadro, ok);
        end
        esperar_fim(ok);
        checks++;
        if (!ok || erro_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tie_no_error: got fim_ok=%b erro=%b expected 1 0", ok, erro_timeout);
        end
        tick();
    endtask

    task automatic test_invalid_bcd();
        logic [63:0] quadro;
        logic [1:0]  sels;
        bit          ok;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        varrer(12'h1A3, 2, 12'h000, 1, quadro, sels, ok);
        checks++;
        if (!ok || quadro !== "1?3,000#") begin
            errors++;
            $display("FAIL bcd_bytes: got %s ok=%b expected 1?3,000#", quadro, ok);
        end
        esperar_fim(ok);
        checks++;
        if (!ok || erro_timeout !== 1'b0) begin
            errors++;
            $display("FAIL bcd_no_error: got fim_ok=%b erro=%b expected 1 0", ok, erro_timeout);
        end
        tick();
    endtask

    task automatic test_ignored_inputs();
        logic [63:0] quadro;
        logic        sel;
        bit          ok;
        int          n;
        bus.pronto_tx     = 1'b1;
        bus.pronto_medida = 1'b1;
        tick();
        bus.pronto_tx     = 1'b0;
        bus.pronto_medida = 1'b0;
        tick();
        checks++;
        if (db_estado !== 4'd0 || bus.medir !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: got estado=%0h medir=%b expected 0 0", db_estado, bus.medir);
        end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        iniciar       = 1'b1;
        bus.pronto_tx = 1'b1;
        tick();
        iniciar       = 1'b0;
        bus.pronto_tx = 1'b0;
        checks++;
        if (db_estado !== 4'd2 || bus.medir !== 1'b0) begin
            errors++;
            $display("FAIL busy_iniciar: got estado=%0h medir=%b expected 2 0", db_estado, bus.medir);
        end
        bus.pronto_medida = 1'b1;
        bus.medida        = 12'h555;
        tick();
        bus.pronto_medida = 1'b0;
        bus.medida        = 12'hEEE;
        quadro = '0;
        receber_bytes(4, quadro, ok);
        servir_sensor(1'b1, 12'h666, 1, quadro, sel, ok);
        checks++;
        if (!ok || quadro !== "555,666#") begin
            errors++;
            $display("FAIL busy_bytes: got %s ok=%b expected 555,666#", quadro, ok);
        end
        esperar_fim(ok);
        n = 0;
        repeat (15) begin
            tick();
            if (bus.medir === 1'b1) n++;
        end
        checks++;
        if (!ok || n != 0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL busy_no_restart: got fim_ok=%b medir_count=%0d ocupado=%b expected 1 0 0", ok, n, ocupado);
        end
    endtask

    task automatic test_continuous();
        logic [63:0] quadro;
        logic [1:0]  sels;
        bit          ok;
        int          n;
        continuo = 1'b1;
        tick();
        checks++;
        if (bus.medir !== 1'b1) begin
            errors++;
            $display("FAIL cont_start: got medir=%b expected 1", bus.medir);
        end
        varrer(12'h111, 2, 12'h222, 2, quadro, sels, ok);
        checks++;
        if (!ok || quadro !== "111,222#") begin
            errors++;
            $display("FAIL cont_bytes1: got %s ok=%b expected 111,222#", quadro, ok);
        end
        esperar_fim(ok);
        n = 0;
        while (bus.medir !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (n == 25) begin
                checks++;
                if (db_estado !== 4'd9 || ocupado !== 1'b1) begin
                    errors++;
                    $display("FAIL cont_intervalo: got estado=%0h ocupado=%b expected 9 1", db_estado, ocupado);
                end
            end
        end
        checks++;
        if (!ok || n != INTERVALO_CICLOS) begin
            errors++;
            $display("FAIL cont_interval: got %0d cycles expected %0d", n, INTERVALO_CICLOS);
        end
        continuo = 1'b0;
        varrer(12'h333, 0, 12'h444, 3, quadro, sels, ok);
        checks++;
        if (!ok || quadro !== "333,444#") begin
            errors++;
            $display("FAIL cont_bytes2: got %s ok=%b expected 333,444#", quadro, ok);
        end
        esperar_fim(ok);
        tick();
        checks++;
        if (!ok || db_estado !== 4'd0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop: got fim_ok=%b estado=%0h ocupado=%b expected 1 0 0", ok, db_estado, ocupado);
        end
        n = 0;
        repeat (60) begin
            tick();
            if (bus.medir === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL cont_no_restart: got %0d medir pulses expected 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_latency_and_reset();
        test_timeout();
        test_expiry_tie();
        test_invalid_bcd();
        test_ignored_inputs();
        test_continuous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
